// File: rtl/decoder_pkg.sv
// Shared types and helpers for the one-hot scan decoder: FSM states, mode
// encodings and a range-checked one-hot builder.
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Out-of-range indices give all-zero, never X, so callers can decode blindly.
  function automatic logic [63:0] onehot(input logic [31:0] idx, input logic [31:0] n);
    logic [63:0] r;
    r = '0;
    if (idx < n) r = 64'd1 << idx;
    return r;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Dwell counter and index incrementer for auto-scan; the caller owns the
// index register and commits next_idx when advance is high.
module scan_timer
  import decoder_pkg::*;
#(
  parameter int unsigned N_OUT   = 10,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [SEL_W-1:0]   cur_idx,
  output logic               advance,
  output logic [SEL_W-1:0]   next_idx,
  output logic               wrap
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_OUT - 1);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = '0;
    advance = 1'b0;
    if (run) begin
      // >= rather than == so a dwell lowered below the count advances at once.
      if (cnt_q >= dwell) advance = 1'b1;
      else                cnt_d   = cnt_q + DWELL_W'(1);
    end
  end

  assign next_idx = (cur_idx == LAST_IDX) ? '0 : cur_idx + SEL_W'(1);
  assign wrap     = advance && (cur_idx == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with direct-decode and auto-scan modes,
// used for display digit and keypad row selects.
module onehot_scan_decoder
  import decoder_pkg::*;
#(
  parameter int unsigned N_OUT   = 10,
  parameter int unsigned SEL_W   = 4,
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic               sel_valid,
  input  logic [DWELL_W-1:0] dwell,
  output logic [N_OUT-1:0]   out,
  output logic [SEL_W-1:0]   cur_idx,
  output logic               err,
  output logic               wrap
);

  state_e             state_q, state_d;
  logic [N_OUT-1:0]   out_q, out_d;
  logic [SEL_W-1:0]   cur_idx_q, cur_idx_d;
  logic               err_q, err_d;
  logic               wrap_q, wrap_d;

  logic               run;
  logic               advance;
  logic [SEL_W-1:0]   next_idx;
  logic               wrap_hit;

  // The counter only runs while scanning steadily; entry and every other state clear it.
  assign run = en && (mode == MODE_SCAN) && (state_q == SCAN);

  scan_timer #(
    .N_OUT   (N_OUT),
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_scan_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .dwell    (dwell),
    .cur_idx  (cur_idx_q),
    .advance  (advance),
    .next_idx (next_idx),
    .wrap     (wrap_hit)
  );

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    cur_idx_d = cur_idx_q;
    err_d     = 1'b0;
    wrap_d    = 1'b0;

    if (!en) begin
      state_d = IDLE;
      out_d   = '0;
    end else if (mode == MODE_SCAN) begin
      if (state_q != SCAN) begin
        state_d   = SCAN;
        cur_idx_d = '0;
        out_d     = N_OUT'(onehot(32'd0, N_OUT));
      end else if (advance) begin
        cur_idx_d = next_idx;
        out_d     = N_OUT'(onehot(32'(next_idx), N_OUT));
        wrap_d    = wrap_hit;
      end
    end else begin
      state_d = DIRECT;
      if (sel_valid) begin
        // onehot() already yields zero out of range; cur_idx must still hold.
        out_d = N_OUT'(onehot(32'(sel), N_OUT));
        if (32'(sel) < N_OUT) cur_idx_d = sel;
        else                  err_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      out_q     <= '0;
      cur_idx_q <= '0;
      err_q     <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      cur_idx_q <= cur_idx_d;
      err_q     <= err_d;
      wrap_q    <= wrap_d;
    end
  end

  assign out     = out_q;
  assign cur_idx = cur_idx_q;
  assign err     = err_q;
  assign wrap    = wrap_q;

endmodule
